// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types, sizes and the rotating priority scan for the round-robin arbiter.
package rr_decode_arbiter_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First asserted bit of r scanning start, start+1, ... (mod N_REQ); returns {hit, index}.
  function automatic logic [IDX_W:0] rr_scan(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] start);
    logic             hit;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] pos;
    hit = 1'b0;
    win = start;
    for (int k = 0; k < int'(N_REQ); k++) begin
      pos = start + IDX_W'(k);
      if (!hit && r[pos]) begin
        hit = 1'b1;
        win = pos;
      end
    end
    return {hit, win};
  endfunction

endpackage

// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesting blocks and the arbiter.
interface rr_decode_arbiter_if;
  import rr_decode_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             preempt;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output preempt
  );
endinterface

// File: rtl/rr_decode_arbiter_dec2_onehot.sv
// 2-to-4 index decoder; en=0 forces an all-zero output.
module dec2_onehot
  import rr_decode_arbiter_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot_c
);

  always_comb begin
    onehot_c = '0;
    if (en) onehot_c[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Four-way round-robin arbiter with grant hold and optional forced rotation after MAX_HOLD cycles.
module rr_decode_arbiter
  import rr_decode_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input logic                clk,
  input logic                rst,
  rr_decode_arbiter_if.slave bus
);

  if ((32'd1 << CNT_W) <= MAX_HOLD) begin : g_cnt_w_check
    $error("CNT_W too narrow for MAX_HOLD");
  end

  state_e           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] hold_cnt;
  logic [N_REQ-1:0] gnt_q;
  logic             gnt_valid_q;
  logic             preempt_q;

  logic [N_REQ-1:0] owner_mask_c;
  logic [N_REQ-1:0] others_c;
  logic [N_REQ-1:0] scan_req_c;
  logic [IDX_W-1:0] scan_start_c;
  logic [IDX_W-1:0] scan_idx_c;
  logic             scan_hit_c;
  logic             own_req_c;
  logic             at_limit_c;
  logic             release_c;
  logic             force_c;
  logic             rearb_c;
  logic [IDX_W-1:0] win_idx_c;
  logic             win_valid_c;
  logic [N_REQ-1:0] gnt_d_c;

  dec2_onehot u_owner_mask (
    .idx      (owner),
    .en       (gnt_valid_q),
    .onehot_c (owner_mask_c)
  );

  dec2_onehot u_gnt_dec (
    .idx      (win_idx_c),
    .en       (win_valid_c),
    .onehot_c (gnt_d_c)
  );

  // Arbitration datapath: decide who owns the resource after the next edge.
  always_comb begin
    own_req_c    = bus.req[owner];
    others_c     = bus.req & ~owner_mask_c;
    at_limit_c   = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD));
    release_c    = (state == GRANT) && !own_req_c;
    force_c      = (state == GRANT) && own_req_c && at_limit_c && (|others_c);
    rearb_c      = (state == IDLE) || release_c || force_c;
    scan_req_c   = force_c ? others_c : bus.req;
    scan_start_c = (state == IDLE) ? ptr : owner + IDX_W'(1);
    {scan_hit_c, scan_idx_c} = rr_scan(scan_req_c, scan_start_c);
    win_valid_c  = rearb_c ? scan_hit_c : 1'b1;
    win_idx_c    = rearb_c ? scan_idx_c : owner;
  end

  // FSM, pointer, hold counter and registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      hold_cnt    <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      gnt_q       <= gnt_d_c;
      gnt_valid_q <= win_valid_c;
      owner       <= win_valid_c ? win_idx_c : '0;
      preempt_q   <= force_c;
      case (state)
        IDLE: begin
          if (win_valid_c) begin
            state    <= GRANT;
            hold_cnt <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (release_c || force_c) begin
            ptr <= owner + IDX_W'(1);
            if (win_valid_c) begin
              hold_cnt <= CNT_W'(1);
            end else begin
              state    <= IDLE;
              hold_cnt <= '0;
            end
          end else if ((MAX_HOLD != 0) && (hold_cnt != CNT_W'(MAX_HOLD))) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = owner;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench: three arbiters (MAX_HOLD 8, 4, 0) on one request stream, each checked against a behavioural model.
module tb_rr_decode_arbiter;
  import rr_decode_arbiter_pkg::*;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;

  int checks   = 0;
  int failures = 0;

  // Model state per instance: owner valid, owner, pointer, hold length, preempt pulse.
  int m_v   [NI];
  int m_idx [NI];
  int m_ptr [NI];
  int m_cnt [NI];
  int m_pre [NI];

  rr_decode_arbiter_if bus0 ();
  rr_decode_arbiter_if bus1 ();
  rr_decode_arbiter_if bus2 ();

  assign bus0.req = req;
  assign bus1.req = req;
  assign bus2.req = req;

  rr_decode_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_h8 (.clk(clk), .rst(rst), .bus(bus0));
  rr_decode_arbiter #(.MAX_HOLD(4), .CNT_W(4)) u_h4 (.clk(clk), .rst(rst), .bus(bus1));
  rr_decode_arbiter #(.MAX_HOLD(0), .CNT_W(4)) u_h0 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  function automatic int max_hold(input int k);
    case (k)
      0:       return 8;
      1:       return 4;
      default: return 0;
    endcase
  endfunction

  // First requester at or after start going round the ring, or -1.
  function automatic int ring_pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic rst_now, input logic [3:0] r);
    int         o;
    int         w;
    logic [3:0] rest;
    for (int k = 0; k < NI; k++) begin
      m_pre[k] = 0;
      if (rst_now) begin
        m_v[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
      end else if (m_v[k] == 0) begin
        w = ring_pick(r, m_ptr[k]);
        if (w >= 0) begin
          m_v[k] = 1; m_idx[k] = w; m_cnt[k] = 1;
        end
      end else begin
        o    = m_idx[k];
        rest = r & ~(4'b0001 << o);
        if (!r[o]) begin
          m_ptr[k] = (o + 1) % 4;
          w = ring_pick(r, m_ptr[k]);
          if (w >= 0) begin
            m_idx[k] = w; m_cnt[k] = 1;
          end else begin
            m_v[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
          end
        end else if (max_hold(k) != 0 && m_cnt[k] == max_hold(k) && rest != 4'b0000) begin
          m_ptr[k] = (o + 1) % 4;
          m_idx[k] = ring_pick(rest, m_ptr[k]);
          m_cnt[k] = 1;
          m_pre[k] = 1;
        end else if (m_cnt[k] < max_hold(k)) begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  task automatic sample(input int k, output logic [3:0] g, output logic [1:0] gi,
                        output logic gv, output logic pe);
    case (k)
      0:       begin g = bus0.gnt; gi = bus0.gnt_idx; gv = bus0.gnt_valid; pe = bus0.preempt; end
      1:       begin g = bus1.gnt; gi = bus1.gnt_idx; gv = bus1.gnt_valid; pe = bus1.preempt; end
      default: begin g = bus2.gnt; gi = bus2.gnt_idx; gv = bus2.gnt_valid; pe = bus2.preempt; end
    endcase
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%0h expected=%0h", name, k, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [3:0] g;
    logic [1:0] gi;
    logic       gv;
    logic       pe;
    logic [3:0] eg;
    for (int k = 0; k < NI; k++) begin
      sample(k, g, gi, gv, pe);
      eg = (m_v[k] != 0) ? (4'b0001 << m_idx[k]) : 4'b0000;
      chk("gnt", k, 32'(g), 32'(eg));
      chk("gnt_valid", k, 32'(gv), 32'(m_v[k] != 0));
      chk("preempt", k, 32'(pe), 32'(m_pre[k] != 0));
      chk("onehot0", k, 32'($onehot0(g)), 32'd1);
      if (m_v[k] != 0) chk("gnt_idx", k, 32'(gi), 32'(m_idx[k]));
      if (gv) chk("gnt_eq_dec_idx", k, 32'(g), 32'(4'b0001 << gi));
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge(rst, req);
    #1;
    compare_all();
  endtask

  task automatic lit(input string name, input int k, input logic [3:0] eg, input logic ep);
    logic [3:0] g;
    logic [1:0] gi;
    logic       gv;
    logic       pe;
    sample(k, g, gi, gv, pe);
    chk({name, "_gnt"}, k, 32'(g), 32'(eg));
    chk({name, "_pre"}, k, 32'(pe), 32'(ep));
  endtask

  logic [3:0] fair_req [9];
  int         fair_own [9];

  initial begin
    logic [3:0] g;
    logic [1:0] gi;
    logic       gv;
    logic       pe;

    // Reset state
    rst = 1'b1; req = 4'b0000;
    step();
    step();
    for (int k = 0; k < NI; k++) lit("reset", k, 4'b0000, 1'b0);
    rst = 1'b0;
    step();

    // Latency from IDLE and release back to idle
    req = 4'b0100;
    step();
    sample(0, g, gi, gv, pe);
    chk("lat_gnt", 0, 32'(g), 32'h4);
    chk("lat_idx", 0, 32'(gi), 32'd2);
    chk("lat_valid", 0, 32'(gv), 32'd1);
    req = 4'b0000;
    step();
    lit("drop", 0, 4'b0000, 1'b0);

    // Reset in the middle of a grant
    req = 4'b0100;
    step();
    lit("pre_rst", 1, 4'b0100, 1'b0);
    rst = 1'b1;
    step();
    sample(1, g, gi, gv, pe);
    chk("midrst_gnt", 1, 32'(g), 32'h0);
    chk("midrst_valid", 1, 32'(gv), 32'd0);
    rst = 1'b0; req = 4'b0001;
    step();
    lit("after_rst", 1, 4'b0001, 1'b0);
    req = 4'b0000;
    step();

    // Forced rotation with two steady requesters, starting from pointer 0
    rst = 1'b1;
    step();
    rst = 1'b0; req = 4'b0011;
    for (int s = 1; s <= 20; s++) begin
      step();
      lit("rot4", 1, (((s - 1) / 4) % 2 == 0) ? 4'b0001 : 4'b0010, (s > 1) && ((s - 1) % 4 == 0));
      lit("nohold", 2, 4'b0001, 1'b0);
      if (s == 8) lit("rot8_hold", 0, 4'b0001, 1'b0);
      if (s == 9) lit("rot8_pre", 0, 4'b0010, 1'b1);
    end
    req = 4'b0000;
    step();

    // Sole requester never preempted
    req = 4'b1000;
    for (int s = 1; s <= 20; s++) begin
      step();
      lit("sole", 1, 4'b1000, 1'b0);
    end
    req = 4'b0000;
    step();

    // Fairness: each owner drops for one cycle after two cycles of grant
    fair_req = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101, 4'b1111, 4'b1011, 4'b1111, 4'b0111};
    fair_own = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int s = 0; s < 9; s++) begin
      req = fair_req[s];
      step();
      lit("fair", 0, 4'b0001 << fair_own[s], 1'b0);
      lit("fair", 1, 4'b0001 << fair_own[s], 1'b0);
    end
    req = 4'b0000;
    step();

    // Random traffic with occasional resets
    for (int s = 0; s < 4000; s++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      step();
    end
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Four-requester round-robin arbiter sharing one downstream resource.
- Winner index is produced as a 2-bit code and expanded to a one-hot grant by an internal 2-to-4 decoder stage.
- Grant is held while the owner keeps requesting. An optional hold limit forces rotation when others are waiting.
- Sits between requesting blocks and the shared datapath; gnt[3:0] drives that datapath's select/enable lines directly.

Parameters:
- MAX_HOLD, 8: max consecutive grant cycles before forced rotation if another request is pending; 0 disables preemption.
- CNT_W, 4: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset, sampled on rising edge of clk.
- req, input, 4: request vector, bit i = requester i; level-sensitive.
- gnt, output, 4: one-hot grant, registered; all zero when no owner.
- gnt_idx, output, 2: binary index of current owner; valid only when gnt_valid=1.
- gnt_valid, output, 1: 1 while any grant bit is set.
- preempt, output, 1: one-cycle pulse in the cycle the new grant appears after a forced rotation.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, gnt=4'b0000, gnt_idx=2'd0, gnt_valid=0, preempt=0, ptr=2'd0 (req[0] highest priority), hold_cnt=0. Reset overrides everything, including mid-grant: the grant drops at that edge with no release cycle.
- Priority search: pick the first asserted req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). Pure combinational, no wait states.
- State IDLE:
  - If req!=0 at an edge: register the winner. gnt/gnt_idx/gnt_valid become valid after that edge (1-cycle latency from req to gnt). Go to GRANT, hold_cnt=1.
  - If req==0: stay IDLE, outputs zero.
- State GRANT, owner o, evaluated at each edge:
  - Release, when req[o]=0: ptr <= o+1 (mod 4). Scan req from o+1. If any bit is set, grant it at this edge, stay in GRANT, hold_cnt=1 (zero-gap handover). Otherwise gnt=0 and go to IDLE.
  - Preempt, when req[o]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD, and (req & ~onehot(o))!=0:
    - ptr <= o+1; scan from o+1 excluding o; grant the winner; hold_cnt=1; preempt=1 for one cycle.
    - The preempted owner keeps its req asserted and is re-served in turn.
  - Hold, otherwise: keep grant. hold_cnt increments and saturates at MAX_HOLD (no wrap).
  - Sole requester with hold_cnt at limit: keeps grant indefinitely, no preempt pulse.
- Simultaneous release and new request from the same requester in the same cycle cannot occur (level signal). A requester that drops req for one cycle and reasserts is re-arbitrated normally.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt == dec(gnt_idx) whenever gnt_valid=1.
  - gnt changes only at clock edges.
  - No owner is granted while its req is low, except the single cycle after its release edge is sampled.

Decomposition:
- Shared package:
  - state enum {IDLE, GRANT}
  - constant N_REQ=4
  - constant IDX_W=2
- Sub-module dec2_onehot: 2-bit index in, 4-bit one-hot out, plus an enable input that forces output zero. Used for gnt generation and for the ~onehot(o) exclusion mask.
- Priority scan, pointer, and hold counter stay in the top module.

Test Plan:
- Reset mid-grant: owner 2 granted, assert rst for 1 cycle -> gnt=0000, gnt_valid=0 after that edge. Then req=0001 -> gnt=0001 one cycle later (ptr back to 0).
- Round-robin fairness: req=1111 held, each owner drops req after 2 cycles then reasserts -> grant sequence 0,1,2,3,0 with zero idle cycles between owners.
- Latency/idle: from IDLE, req=0100 at edge k -> gnt=0100, gnt_idx=2, gnt_valid=1 visible after edge k. Drop req -> gnt=0000 after next edge.
- Preemption: MAX_HOLD=4, req=0011 held continuously -> owner 0 holds 4 cycles, then gnt=0010 with preempt=1 for 1 cycle, 4 cycles later gnt=0001 with preempt pulse again.
- Sole requester: MAX_HOLD=4, req=1000 for 20 cycles -> gnt=1000 throughout, preempt never asserted, hold_cnt saturates at 4.
- MAX_HOLD=0: req=0011 for 20 cycles -> gnt stays 0001 and preempt stays 0 until req[0] drops. Random-stimulus run checks gnt one-hot/zero and gnt==dec(gnt_idx) every cycle.
